// File: rtl/aq_mmu_pkg.sv
// Shared MMU constants and the JTLB tag sequencer state encoding.
package aq_mmu_pkg;

  localparam int unsigned IDX_W         = 6;
  localparam int unsigned WAY_W         = 48;
  localparam int unsigned ARR_IDX_W     = 9;
  localparam int unsigned WEN_W         = 3;
  localparam int unsigned JTLB_W        = 98;
  localparam int unsigned JTLB_WAY1_LSB = 48;
  localparam int unsigned JTLB_FIFO_LSB = 96;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RF_RD = 2'd1,
    ST_RF_WR = 2'd2,
    ST_INV   = 2'd3
  } jtlb_tag_state_e;

endpackage

// File: rtl/aq_mmu_jtlb_tag_ctrl.sv
// JTLB tag SRAM sequencer: arbitrates lookup reads, refill read-modify-write
// with FIFO victim choice, and the invalidate-all sweep onto one array port.
// Build option: MMU_JTLB_RST_INV_EN makes reset land in the sweep state so the
// array is cleared automatically after reset release.
module aq_mmu_jtlb_tag_ctrl
  import aq_mmu_pkg::*;
(
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 lkup_req,
  input  logic [IDX_W-1:0]     lkup_idx,
  output logic                 lkup_gnt,
  output logic                 lkup_rvld,
  output logic [JTLB_W-1:0]    lkup_rdata,
  input  logic                 rf_req,
  input  logic [IDX_W-1:0]     rf_idx,
  input  logic [WAY_W-1:0]     rf_tag,
  output logic                 rf_done,
  output logic                 rf_way,
  input  logic                 inv_req,
  output logic                 inv_done,
  output logic                 ctrl_busy,
  output logic                 jtlb_tag_cen,
  output logic [WEN_W-1:0]     jtlb_tag_wen,
  output logic [ARR_IDX_W-1:0] jtlb_tag_idx,
  output logic [JTLB_W-1:0]    jtlb_tag_din,
  input  logic [JTLB_W-1:0]    jtlb_tag_dout
);

`ifdef MMU_JTLB_RST_INV_EN
  localparam jtlb_tag_state_e RST_ST = ST_INV;
`else
  localparam jtlb_tag_state_e RST_ST = ST_IDLE;
`endif

  localparam logic [IDX_W-1:0] CNT_LAST = '1;

  jtlb_tag_state_e    state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rf_idx_q, rf_idx_d;
  logic [WAY_W-1:0]   rf_tag_q, rf_tag_d;
  logic               victim_q, victim_d;
  logic               lkup_rvld_q, lkup_rvld_d;

  logic               cen_c;
  logic [WEN_W-1:0]   wen_c;
  logic [IDX_W-1:0]   idx_c;
  logic [JTLB_W-1:0]  din_c;
  logic               gnt_c;
  logic               rf_done_c;
  logic               inv_done_c;
  logic               busy_c;

  // State, sweep counter, refill context and lookup-return flag
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q     <= RST_ST;
      cnt_q       <= '0;
      rf_idx_q    <= '0;
      rf_tag_q    <= '0;
      victim_q    <= 1'b0;
      lkup_rvld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rf_idx_q    <= rf_idx_d;
      rf_tag_q    <= rf_tag_d;
      victim_q    <= victim_d;
      lkup_rvld_q <= lkup_rvld_d;
    end
  end

  // Next-state and array-port decode; one array access per cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rf_idx_d    = rf_idx_q;
    rf_tag_d    = rf_tag_q;
    victim_d    = victim_q;
    lkup_rvld_d = 1'b0;
    cen_c       = 1'b0;
    wen_c       = '0;
    idx_c       = '0;
    din_c       = '0;
    gnt_c       = 1'b0;
    rf_done_c   = 1'b0;
    inv_done_c  = 1'b0;
    busy_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (inv_req) begin
          cnt_d   = '0;
          state_d = ST_INV;
        end else if (rf_req) begin
          rf_idx_d = rf_idx;
          rf_tag_d = rf_tag;
          cen_c    = 1'b1;
          idx_c    = rf_idx;
          state_d  = ST_RF_RD;
        end else if (lkup_req) begin
          cen_c       = 1'b1;
          idx_c       = lkup_idx;
          gnt_c       = 1'b1;
          lkup_rvld_d = 1'b1;
        end
      end

      ST_RF_RD: begin
        // FIFO bit points at the older way, which becomes the victim
        busy_c   = 1'b1;
        victim_d = jtlb_tag_dout[JTLB_FIFO_LSB];
        state_d  = ST_RF_WR;
      end

      ST_RF_WR: begin
        // Write the new tag into the victim way and flip the FIFO pointer
        busy_c    = 1'b1;
        cen_c     = 1'b1;
        idx_c     = rf_idx_q;
        wen_c     = {1'b1, victim_q, ~victim_q};
        din_c[0 +: WAY_W]             = rf_tag_q;
        din_c[JTLB_WAY1_LSB +: WAY_W] = rf_tag_q;
        din_c[JTLB_FIFO_LSB +: 2]     = {1'b0, ~victim_q};
        rf_done_c = 1'b1;
        state_d   = ST_IDLE;
      end

      ST_INV: begin
        busy_c = 1'b1;
        cen_c  = 1'b1;
        wen_c  = '1;
        idx_c  = cnt_q;
        cnt_d  = cnt_q + IDX_W'(1);
        if (cnt_q == CNT_LAST) begin
          inv_done_c = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs forced quiet while reset is sampled low so aborted work never
  // touches the array or pulses a done flag
  assign lkup_gnt     = cpurst_b & gnt_c;
  assign lkup_rvld    = cpurst_b & lkup_rvld_q;
  assign lkup_rdata   = lkup_rvld ? jtlb_tag_dout : '0;
  assign rf_done      = cpurst_b & rf_done_c;
  assign rf_way       = rf_done & victim_q;
  assign inv_done     = cpurst_b & inv_done_c;
  assign ctrl_busy    = cpurst_b & busy_c;
  assign jtlb_tag_cen = cpurst_b & cen_c;
  assign jtlb_tag_wen = cpurst_b ? wen_c : '0;
  assign jtlb_tag_idx = cpurst_b ? ARR_IDX_W'(idx_c) : '0;
  assign jtlb_tag_din = cpurst_b ? din_c : '0;

endmodule

// File: doc/aq_mmu_jtlb_tag_ctrl.md
# aq_mmu_jtlb_tag_ctrl

Sequencer and arbiter for the JTLB tag SRAM wrapper (98-bit entry: way0 [47:0], way1 [95:48], FIFO replacement field [97:96]). Shares the single-port array between three requesters: TLB lookup reads, PTW refill (read-modify-write with FIFO victim selection), and sfence invalidate-all sweep. Sits in the MMU between the TLB/PTW logic and the tag-array wrapper, and drives its cen/wen/idx/din.

## Interface
- IDX_W, 6: array index width (64 sets); upper bits of the 9-bit idx bus tied 0
- WAY_W, 48: per-way tag width; bit WAY_W-1 is the valid bit
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  reset, synchronous, active-low
- lkup_req  in  1  lookup read request
- lkup_idx  in  IDX_W  lookup set index
- lkup_gnt  out  1  lookup accepted this cycle
- lkup_rvld  out  1  lookup data valid (cycle after grant)
- lkup_rdata  out  98  raw array output, valid with lkup_rvld
- rf_req  in  1  refill request; held until rf_done
- rf_idx  in  IDX_W  refill set index
- rf_tag  in  WAY_W  new way entry (valid bit set by requester)
- rf_done  out  1  one-cycle pulse when refill write issued
- rf_way  out  1  victim way chosen, valid with rf_done
- inv_req  in  1  invalidate-all request; held until inv_done
- inv_done  out  1  one-cycle pulse after last set cleared
- ctrl_busy  out  1  sweep or refill in progress
- jtlb_tag_cen  out  1  array enable, active-high
- jtlb_tag_wen  out  3  byte-group write enable {fifo, way1, way0}
- jtlb_tag_idx  out  9  array index, {0, idx[IDX_W-1:0]}
- jtlb_tag_din  out  98  write data
- jtlb_tag_dout  in  98  array read data, one cycle after read

## Operation
- FSM states: IDLE, RF_RD, RF_WR, INV. Reset -> IDLE (or INV, see Configuration).
- Priority in IDLE: inv_req > rf_req > lkup_req. Only one array access per cycle.
- IDLE + lkup_req (no higher request): cen=1, wen=0, idx=lkup_idx, lkup_gnt=1; lkup_rvld=1 next cycle with lkup_rdata=jtlb_tag_dout.
- IDLE + rf_req: latch rf_idx/rf_tag; issue read of rf_idx (cen=1, wen=0); -> RF_RD.
- RF_RD: dout available; victim = dout[96]; -> RF_WR.
- RF_WR: cen=1, idx=latched idx, wen={1, victim, ~victim}, din={1'b0, ~victim, rf_tag, rf_tag}; rf_done=1, rf_way=victim; -> IDLE.
- IDLE + inv_req: clear 6-bit counter; -> INV. Each INV cycle: cen=1, wen=3'b111, din=0, idx=counter; counter+1. On counter==2^IDX_W-1: inv_done=1 same cycle, -> IDLE.
- lkup_gnt=0 in all non-IDLE states and when a higher request is present; lookup requester retries.
- inv_req arriving during RF_RD/RF_WR: refill completes first, sweep starts next IDLE cycle.
- ctrl_busy=1 in RF_RD, RF_WR, INV.
- When cen=0: wen=0, idx=0, din=0 (no X on array pins).

## Timing
- Reset values: all outputs 0; state IDLE; counter 0; latched idx/tag 0.
- Lookup: grant cycle N, data cycle N+1; back-to-back lookups sustain one per cycle.
- Refill: request seen cycle N -> read N, rf_done N+2; 3 cycles of array occupancy.
- Sweep: 2^IDX_W write cycles; inv_done on the last write cycle.
- Reset asserted mid-refill or mid-sweep: next edge aborts to reset state; partial sweep is not resumed; rf_done/inv_done never pulse for aborted operation.
- lkup_rvld is not suppressed by a following refill grant; returned data belongs to the granted index.

## Configuration
- MMU_JTLB_RST_INV_EN defined: reset state is INV; full sweep runs automatically after reset release, ctrl_busy=1 throughout, inv_done pulses at end; lookups/refills blocked until done.
- Undefined: reset state IDLE; array contents undefined until software sfence (inv_req).

## Structure
- Shared package (aq_mmu_pkg): FSM state encoding, JTLB_FIFO_LSB=96, JTLB_WAY1_LSB=48, WAY_W default.
- No sub-module; single FSM plus counter. Instantiated beside the tag-array wrapper, same clock domain (gating handled inside the wrapper).

## Test plan
- Reset with macro on -> 64 writes idx 0..63, wen=3'b111, din=0; inv_done on cycle 64; lkup_gnt held 0 until then.
- lkup_req idx=5 after init -> gnt cycle N, rvld cycle N+1, rdata=0.
- rf_req idx=5 tag=48'h8000_0000_1234 -> write wen=3'b101, way0 written, din[96]=1, rf_way=0; repeat -> wen=3'b110, rf_way=1, din[96]=0.
- Simultaneous inv_req, rf_req, lkup_req in IDLE -> sweep first, then refill, lookup granted only after both.
- cpurst_b low during INV at counter=20 -> all outputs 0 next cycle, no inv_done; restart sweep from 0 (macro on).
- Back-to-back lookups idx 1,2,3 -> three grants, rvld three consecutive cycles with matching data.
